// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry downlink transmitter.
//   SYNC0/SYNC1   : frame preamble bytes
//   frame_state_e : frame sequencer states (state names the byte currently on the line)
//   tx_state_e    : byte serialiser states
//   bit_ticks()   : clock cycles per serial bit
package telemetry_pkg;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  typedef enum logic [2:0] {
    StIdle,
    StSync0,
    StSync1,
    StSeq,
    StLen,
    StPayload,
    StChk
  } frame_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  // Plain integer division; no fractional baud correction.
  function automatic int unsigned bit_ticks(input int unsigned clk_freq,
                                            input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with a valid/ready handshake.
//   clk, reset : clock, asynchronous active-high reset
//   valid_i    : byte offered on data_i
//   data_i     : byte to send, LSB first
//   ready_o    : high when idle or in the last cycle of the stop bit
//   txd_o      : serial line, idle high
// A handshake in the last stop cycle starts the next start bit on the following
// cycle, so consecutive bytes leave with no idle gap.
module uart_tx_byte
  import telemetry_pkg::*;
#(
  parameter int unsigned BitTicks = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       txd_o
);

  localparam int unsigned CntW = (BitTicks > 1) ? $clog2(BitTicks) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BitTicks - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntLast);
  assign ready_o = (state_q == TxIdle) || ((state_q == TxStop) && bit_end);
  assign txd_o   = txd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;

    unique case (state_q)
      TxIdle:  cnt_d = '0;
      TxStart: if (bit_end) state_d = TxData;
      TxData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = TxStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      TxStop:  if (bit_end) state_d = TxIdle;
      default: state_d = TxIdle;
    endcase

    if (valid_i && ready_o) begin
      state_d = TxStart;
      shift_d = data_i;
      bit_d   = '0;
      cnt_d   = '0;
    end

    // Line level registered from the next state so TxD is glitch-free.
    txd_d = 1'b1;
    if (state_d == TxStart)     txd_d = 1'b0;
    else if (state_d == TxData) txd_d = shift_d[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/telemetry_uart_tx.sv
// Telemetry downlink: snapshots NUM_WORDS 16-bit words on send and transmits
// AA 55 SEQ LEN payload CHK as back-to-back 8N1 bytes.
//   clk, reset : clock, asynchronous active-high reset
//   send       : one-cycle frame request
//   words_in   : payload, word 0 in bits [15:0], each word sent MSB byte first
//   busy       : frame in flight
//   frame_done : one-cycle pulse after the last stop bit
//   dropped    : one-cycle pulse after a send that arrived while busy
//   TxD        : serial line, idle high
module telemetry_uart_tx
  import telemetry_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   send,
  input  logic [16*NUM_WORDS-1:0] words_in,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   dropped,
  output logic                   TxD
);

  localparam int unsigned BitTicks = bit_ticks(CLK_FREQ, BAUD);
  localparam logic [7:0]  Len      = 8'(2 * NUM_WORDS);
  localparam int unsigned SelW     = $clog2(16 * NUM_WORDS);

  frame_state_e            state_q, state_d;
  logic [16*NUM_WORDS-1:0] snap_q, snap_d;
  logic [7:0]              idx_q, idx_d;
  logic [7:0]              seq_q, seq_d;
  logic [7:0]              chk_q, chk_d;
  logic                    frame_done_q, frame_done_d;
  logic                    dropped_q, dropped_d;

  logic            tx_valid, tx_ready, hs, add_chk;
  logic [7:0]      tx_data, pay_byte, pay_idx;
  logic [SelW-1:0] sel;

  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign dropped    = dropped_q;
  assign hs         = tx_valid && tx_ready;

  // Payload byte idx: flipping idx[0] puts the high byte of each word first.
  always_comb begin
    pay_idx  = (idx_q < Len) ? idx_q : '0;
    sel      = SelW'({pay_idx ^ 8'd1, 3'b000});
    pay_byte = snap_q[sel +: 8];
  end

  // The state names the byte on the line; each state offers the following byte
  // so the serialiser can chain it without a gap.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    chk_d        = chk_q;
    tx_valid     = 1'b0;
    tx_data      = SYNC0;
    add_chk      = 1'b0;
    frame_done_d = 1'b0;
    dropped_d    = send && busy;

    unique case (state_q)
      StIdle:  tx_valid = send;
      StSync0: begin tx_valid = 1'b1; tx_data = SYNC1; end
      StSync1: begin tx_valid = 1'b1; tx_data = seq_q; add_chk = 1'b1; end
      StSeq:   begin tx_valid = 1'b1; tx_data = Len;   add_chk = 1'b1; end
      StLen:   begin tx_valid = 1'b1; tx_data = pay_byte; add_chk = 1'b1; end
      StPayload: begin
        tx_valid = 1'b1;
        if (idx_q == Len) begin
          tx_data = chk_q;
        end else begin
          tx_data = pay_byte;
          add_chk = 1'b1;
        end
      end
      StChk:   tx_valid = 1'b0;
      default: state_d = StIdle;
    endcase

    if (hs) begin
      if (add_chk) chk_d = chk_q + tx_data;
      unique case (state_q)
        StIdle: begin
          state_d = StSync0;
          snap_d  = words_in;
          chk_d   = '0;
          idx_d   = '0;
        end
        StSync0: state_d = StSync1;
        StSync1: state_d = StSeq;
        StSeq:   state_d = StLen;
        StLen: begin
          state_d = StPayload;
          idx_d   = idx_q + 8'd1;
        end
        StPayload: begin
          if (idx_q == Len) state_d = StChk;
          else              idx_d   = idx_q + 8'd1;
        end
        default: state_d = state_q;
      endcase
    end

    // Serialiser ready while on CHK means the last stop bit is ending.
    if ((state_q == StChk) && tx_ready) begin
      state_d      = StIdle;
      frame_done_d = 1'b1;
      seq_d        = seq_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      snap_q       <= '0;
      idx_q        <= '0;
      seq_q        <= '0;
      chk_q        <= '0;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      chk_q        <= chk_d;
      frame_done_q <= frame_done_d;
      dropped_q    <= dropped_d;
    end
  end

  uart_tx_byte #(
    .BitTicks(BitTicks)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .valid_i(tx_valid),
    .data_i (tx_data),
    .ready_o(tx_ready),
    .txd_o  (TxD)
  );

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// Directed bench for telemetry_uart_tx. Main instance: BIT_TICKS=4, NUM_WORDS=4
// (520-cycle frames). A second instance with BIT_TICKS=1, NUM_WORDS=1 exercises
// the 256-frame sequence wrap in a short run.
module tb_telemetry_uart_tx;

  localparam int FrameCyc = 520;
  localparam int WFrameCyc = 70;
  localparam logic [63:0] WBasic = 64'hFF00_0001_ABCD_1234;

  logic        clk = 1'b0;
  logic        reset;
  logic        send, busy, frame_done, dropped, txd;
  logic [63:0] words_in;
  logic        send_w, busy_w, done_w, dropped_w, txd_w;
  logic [15:0] words_w;

  int   nvec = 0;
  int   nfail = 0;
  int   drop_seen;
  logic line_q [0:FrameCyc-1];

  always #5 clk = ~clk;

  telemetry_uart_tx #(
    .CLK_FREQ (16),
    .BAUD     (4),
    .NUM_WORDS(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .send      (send),
    .words_in  (words_in),
    .busy      (busy),
    .frame_done(frame_done),
    .dropped   (dropped),
    .TxD       (txd)
  );

  telemetry_uart_tx #(
    .CLK_FREQ (4),
    .BAUD     (4),
    .NUM_WORDS(1)
  ) dut_w (
    .clk       (clk),
    .reset     (reset),
    .send      (send_w),
    .words_in  (words_w),
    .busy      (busy_w),
    .frame_done(done_w),
    .dropped   (dropped_w),
    .TxD       (txd_w)
  );

  // Called at a negedge; returns at the negedge holding the first start-bit sample.
  task automatic start_frame(input logic [63:0] w);
    words_in = w;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Samples one frame from its first cycle, then checks completion and each byte.
  task automatic capture_frame(input string name, input logic [103:0] exp_bytes,
                               input bit chain, input int drop_at,
                               input logic [63:0] drop_words);
    int busy_cnt, done_cnt;
    logic [9:0] act, sym;
    logic [7:0] b;
    logic s;
    busy_cnt = 0;
    done_cnt = 0;
    drop_seen = 0;
    for (int i = 0; i < FrameCyc; i++) begin
      line_q[i] = txd;
      if (busy) busy_cnt++;
      if (frame_done) done_cnt++;
      if (dropped) drop_seen++;
      if (i == drop_at) begin
        send = 1'b1;
        words_in = drop_words;
      end else begin
        send = 1'b0;
      end
      @(negedge clk);
    end
    nvec++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s end: frame_done=%b busy=%b, want 1 0", name, frame_done, busy);
    end
    nvec++;
    if (busy_cnt != FrameCyc) begin
      nfail++;
      $display("FAIL %s busy cycles: %0d, want %0d", name, busy_cnt, FrameCyc);
    end
    nvec++;
    if (done_cnt != 0) begin
      nfail++;
      $display("FAIL %s early frame_done: %0d pulses, want 0", name, done_cnt);
    end
    for (int bi = 0; bi < 13; bi++) begin
      b = exp_bytes[103-8*bi -: 8];
      sym = {1'b1, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
        s = line_q[bi*40 + j*4];
        for (int k = 1; k < 4; k++) if (line_q[bi*40 + j*4 + k] !== s) s = 1'bx;
        act[j] = s;
      end
      nvec++;
      if (act !== sym) begin
        nfail++;
        $display("FAIL %s byte %0d: line symbol %b, want %b", name, bi, act, sym);
      end
    end
    if (chain) begin
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nvec++;
    if ({txd, busy, frame_done, dropped} !== 4'b1000) begin
      nfail++;
      $display("FAIL reset_hold: TxD/busy/done/dropped=%b, want 1000",
               {txd, busy, frame_done, dropped});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({txd, busy, frame_done, dropped} !== 4'b1000) begin
      nfail++;
      $display("FAIL reset_idle: TxD/busy/done/dropped=%b, want 1000",
               {txd, busy, frame_done, dropped});
    end
  endtask

  task automatic test_all_zero();
    start_frame(64'h0);
    capture_frame("all_zero", 104'hAA55_0008_0000_0000_0000_0000_08, 1'b0, -1, 64'h0);
  endtask

  task automatic test_reset_mid_frame();
    repeat (3) @(negedge clk);
    start_frame(WBasic);
    repeat (177) @(negedge clk);
    // Inside data bit 3 of payload byte 0x12, which is a 0.
    nvec++;
    if (txd !== 1'b0) begin
      nfail++;
      $display("FAIL mid_frame_line: TxD=%b, want 0", txd);
    end
    reset = 1'b1;
    #1;
    nvec++;
    if ({txd, busy, frame_done, dropped} !== 4'b1000) begin
      nfail++;
      $display("FAIL reset_async: TxD/busy/done/dropped=%b, want 1000",
               {txd, busy, frame_done, dropped});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if ({txd, busy, frame_done, dropped} !== 4'b1000) begin
      nfail++;
      $display("FAIL reset_after: TxD/busy/done/dropped=%b, want 1000",
               {txd, busy, frame_done, dropped});
    end
  endtask

  task automatic test_basic_frame();
    start_frame(WBasic);
    capture_frame("basic", 104'hAA55_0008_1234_ABCD_0001_FF00_C6, 1'b1, -1, 64'h0);
    nvec++;
    if (drop_seen != 0) begin
      nfail++;
      $display("FAIL basic dropped: %0d pulses, want 0", drop_seen);
    end
  endtask

  // Works on the waveform stored by test_basic_frame.
  task automatic test_bit_timing();
    logic [3:0]  st;
    logic [31:0] data;
    logic [7:0]  edge_bits;
    for (int i = 0; i < 4; i++) st[i] = line_q[i];
    for (int i = 0; i < 32; i++) data[i] = line_q[4 + i];
    for (int i = 0; i < 8; i++) edge_bits[i] = line_q[36 + i];
    nvec++;
    if (st !== 4'b0000) begin
      nfail++;
      $display("FAIL start_bit: cycles 0-3 = %b, want 0000", st);
    end
    nvec++;
    if (data !== 32'hF0F0_F0F0) begin
      nfail++;
      $display("FAIL data_bits_AA: %h, want f0f0f0f0", data);
    end
    nvec++;
    if (edge_bits !== 8'h0F) begin
      nfail++;
      $display("FAIL stop_to_start: %b, want 00001111", edge_bits);
    end
  endtask

  task automatic test_back_to_back();
    capture_frame("back_to_back", 104'hAA55_0108_1234_ABCD_0001_FF00_C7, 1'b0, -1, 64'h0);
  endtask

  task automatic test_drop_snapshot();
    repeat (2) @(negedge clk);
    start_frame(WBasic);
    capture_frame("drop_snapshot", 104'hAA55_0208_1234_ABCD_0001_FF00_C8, 1'b0, 99,
                  64'h5555_6666_7777_8888);
    nvec++;
    if (drop_seen != 1) begin
      nfail++;
      $display("FAIL dropped_pulses: %0d, want 1", drop_seen);
    end
    words_in = WBasic;
  endtask

  task automatic test_seq_wrap();
    logic lw [0:WFrameCyc-1];
    logic [9:0] seq_sym, chk_sym;
    logic [7:0] seq_e;
    @(negedge clk);
    words_w = 16'h0102;
    send_w = 1'b1;
    @(negedge clk);
    send_w = 1'b0;
    for (int f = 0; f <= 256; f++) begin
      for (int i = 0; i < WFrameCyc; i++) begin
        lw[i] = txd_w;
        @(negedge clk);
      end
      seq_e = 8'(f % 256);
      for (int j = 0; j < 10; j++) begin
        seq_sym[j] = lw[20 + j];
        chk_sym[j] = lw[60 + j];
      end
      nvec++;
      if (done_w !== 1'b1 || busy_w !== 1'b0) begin
        nfail++;
        $display("FAIL wrap frame %0d end: frame_done=%b busy=%b, want 1 0", f, done_w, busy_w);
      end
      nvec++;
      if (seq_sym !== {1'b1, seq_e, 1'b0}) begin
        nfail++;
        $display("FAIL wrap frame %0d seq: symbol %b, want seq %h", f, seq_sym, seq_e);
      end
      nvec++;
      if (chk_sym !== {1'b1, seq_e + 8'd5, 1'b0}) begin
        nfail++;
        $display("FAIL wrap frame %0d chk: symbol %b, want chk %h", f, chk_sym, seq_e + 8'd5);
      end
      if (f < 256) begin
        send_w = 1'b1;
        @(negedge clk);
        send_w = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    send = 1'b0;
    send_w = 1'b0;
    words_in = '0;
    words_w = '0;
    test_reset();
    test_all_zero();
    test_reset_mid_frame();
    test_basic_frame();
    test_bit_timing();
    test_back_to_back();
    test_drop_snapshot();
    test_seq_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/telemetry_uart_tx.md
Name: telemetry_uart_tx

Overview:
- Downlink counterpart of the UART command receiver.
- Snapshots NUM_WORDS 16-bit telemetry words (pitch/roll/yaw/PWM etc.) on a send strobe.
- Frames them with sync, sequence, length and checksum, then serialises 8N1 on TxD.
- Sits beside the control FSM in the drone top; ground station parses the frame.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; BIT_TICKS = CLK_FREQ/BAUD, integer division (434 at defaults).
- NUM_WORDS, 4, payload words per frame, range 1..127.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- send  in  1  one-cycle request to transmit a frame.
- words_in  in  16*NUM_WORDS  payload; word 0 is bits [15:0].
- busy  out  1  high while a frame is in flight.
- frame_done  out  1  one-cycle pulse when the last stop bit completes.
- dropped  out  1  one-cycle pulse when send arrives while busy.
- TxD  out  1  serial line, idle high.

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Reset values: TxD=1, busy=0, frame_done=0, dropped=0, seq=0x00, frame FSM IDLE, byte TX IDLE.
- Reset mid-frame: TxD returns to 1 asynchronously, the frame is abandoned, seq returns to 0.
- Accept rule:
  - send with busy=0 at edge k: latch words_in, drive busy=1 from k+1, TxD start bit (0) from k+1.
  - send with busy=1: ignored, dropped=1 for the following cycle, snapshot unchanged.
- Frame byte order:
  - 0xAA, 0x55, SEQ, LEN=2*NUM_WORDS.
  - Payload: word 0 first, each word MSB byte first.
  - CHK = (SEQ + LEN + all payload bytes) mod 256.
  - Total: 5+2*NUM_WORDS bytes.
- Byte format: start 0, 8 data bits LSB first, stop 1; each bit is exactly BIT_TICKS cycles.
- Bytes are back-to-back with no idle gap.
- Frame duration: (5+2*NUM_WORDS)*10*BIT_TICKS cycles from start of first start bit to end of last stop bit.
- Completion:
  - At the edge ending the CHK stop bit, busy falls and frame_done pulses for 1 cycle.
  - seq increments by 1 at the same edge; 0xFF wraps to 0x00.
  - send in the frame_done cycle sees busy=0 and is accepted, so the next frame can start 1 cycle after frame_done.
- Checksum: an 8-bit accumulator is cleared on accept and updated as each byte from SEQ through the last payload byte is handed to the byte TX.
- Frame FSM states:
  - IDLE -> SYNC0 on accepted send.
  - SYNC0 -> SYNC1 -> SEQ -> LEN -> PAYLOAD -> CHK -> IDLE.
  - Each transition advances on the byte TX handshake (valid & ready).
  - PAYLOAD uses a byte index 0..2*NUM_WORDS-1 and exits after the last index.
- Byte TX states: IDLE, START, DATA (3-bit bit counter), STOP.
  - ready=1 in IDLE and in the final cycle of STOP.
  - valid & ready in the final STOP cycle enters START on the next cycle (zero gap).
- Baud counter: counts 0..BIT_TICKS-1 and reloads on each bit boundary. There is no fractional baud correction; at defaults the rate error is 0.006%.

Decomposition:
- Package telemetry_pkg holds:
  - constants SYNC0=8'hAA, SYNC1=8'h55;
  - frame state enum typedef;
  - function for BIT_TICKS.
- One sub-module, uart_tx_byte: baud counter plus shift register plus valid/ready handshake (the mirror of async_receiver).
- Frame sequencing, snapshot register, checksum and seq stay in telemetry_uart_tx.

Test Plan:
- Bench uses CLK_FREQ=16, BAUD=4 (BIT_TICKS=4) and NUM_WORDS=4.
- Basic frame: send with words 0x1234, 0xABCD, 0x0001, 0xFF00, seq=0.
  - Required bytes: AA 55 00 08 12 34 AB CD 00 01 FF 00 C6.
  - Frame lasts 520 cycles; frame_done pulses once; busy is high exactly 520 cycles.
- Bit timing: the first start bit is low 4 cycles starting at the edge after send. Data bits of 0xAA read 0,1,0,1,0,1,0,1 (LSB first), 4 cycles each. No idle gap between the stop bit and the next start bit.
- Drop and snapshot: send at t, then send again at t+100 with changed words_in.
  - dropped pulses once.
  - The frame still carries the t snapshot; words_in changes mid-frame do not alter payload.
- Back-to-back frames:
  - send in the frame_done cycle: the second frame starts next cycle with SEQ=01 and CHK incremented by 1 (C7).
  - After 256 frames SEQ wraps to 00.
- Reset mid-frame: assert reset during payload bit 3.
  - TxD=1, busy=0 immediately, with no pulses.
  - The next send produces SEQ=00 and a full, correct frame.
- All-zero words: the frame is AA 55 00 08 00×8 08, with checksum 0x08.
